// File: rtl/cp0_epc_stack_pkg.sv
// Shared CP0 definitions used by the EPC stack and the other CP0 registers.
//   CP0ADDR_EPC : CP0 register number that MTC0 uses to address EPC.
//   EPC_INI     : EPC reset value. It is stored 64 bits wide, and each user
//                 takes the low WIDTH bits.
//   epc_event_e : the one event that an EPC stack acts on in a cycle, after
//                 the exception > eret > mtc0 priority has been applied.
package cp0_epc_stack_pkg;

  localparam logic [5:0]  CP0ADDR_EPC = 6'd14;
  localparam logic [63:0] EPC_INI     = '0;

  typedef enum logic [2:0] {
    EV_NONE,   // idle, or an exception that the classic EXL rule ignores
    EV_PUSH,   // exception that gets a free entry
    EV_OVF,    // exception in nested mode with every entry in use
    EV_POP,    // eret with at least one entry valid
    EV_UNF,    // eret with no entry valid
    EV_WRITE   // MTC0 to EPC
  } epc_event_e;

endpackage

// File: rtl/cp0_epc_stack.sv
// cp0_epc_stack: holds nested EPC values for a MIPS-style CP0.
//   clk, rst_n          : rising-edge clock and synchronous active-low reset
//   exception, BD,      : exception commit, branch-delay flag, and PC of the
//   exc_pc                excepting instruction
//   eret                : ERET commit; it pops one level
//   mtc0_we, cp0_addr,  : MTC0 write. Only the EPC address has an effect.
//   mtc0_data
//   epc_data            : current top entry, or entry[0] when empty
//   EXL                 : high while at least one level is valid
//   level               : number of valid entries
//   ovf                 : sticky; set by an exception when the stack is full
//   unf                 : one-cycle pulse after an eret on an empty stack
module cp0_epc_stack
  import cp0_epc_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NEST  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       exception,
  input  logic                       BD,
  input  logic [WIDTH-1:0]           exc_pc,
  input  logic                       eret,
  input  logic                       mtc0_we,
  input  logic [5:0]                 cp0_addr,
  input  logic [WIDTH-1:0]           mtc0_data,
  output logic [WIDTH-1:0]           epc_data,
  output logic                       EXL,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  output logic                       unf
);

  localparam int unsigned    LW   = $clog2(DEPTH + 1);
  localparam int unsigned    IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0]  FULL = LW'(DEPTH);
  localparam logic [LW-1:0]  ONE  = LW'(1);

  logic [WIDTH-1:0] entry [DEPTH];
  epc_event_e       ev;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    push_idx;
  logic [WIDTH-1:0] push_val;

  // The top of stack is entry[level-1]. When the stack is empty the index
  // falls back to entry[0], so MTC0 writes there and epc_data reads it.
  always_comb begin
    top_idx  = '0;
    if (level != '0) top_idx = IW'(level - ONE);
    // Only used when level < DEPTH, so the value always fits in IW bits.
    push_idx = IW'(level);
    push_val = BD ? (exc_pc - WIDTH'(4)) : exc_pc;
  end

  // Priority: exception > eret > mtc0. A higher-priority request removes
  // any lower one, even when it does nothing itself (for example, a blocked
  // exception in classic mode).
  always_comb begin
    ev = EV_NONE;
    if (exception) begin
      if (level < FULL && (NEST != 0 || level == '0)) ev = EV_PUSH;
      else if (NEST != 0 && level == FULL)             ev = EV_OVF;
      else                                             ev = EV_NONE;
    end else if (eret) begin
      ev = (level != '0) ? EV_POP : EV_UNF;
    end else if (mtc0_we && cp0_addr == CP0ADDR_EPC) begin
      ev = EV_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) entry[i] <= EPC_INI[WIDTH-1:0];
    end else begin
      unf <= 1'b0;
      unique case (ev)
        EV_PUSH: begin
          entry[push_idx] <= push_val;
          level           <= level + ONE;
        end
        EV_OVF:   ovf <= 1'b1;
        EV_POP: begin
          level <= level - ONE;
          if (level == ONE) ovf <= 1'b0;
        end
        EV_UNF:   unf <= 1'b1;
        EV_WRITE: entry[top_idx] <= mtc0_data;
        default:  ;
      endcase
    end
  end

  assign epc_data = entry[top_idx];
  assign EXL      = (level != '0);

endmodule
